// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage that sits after the ALU result mux. An input result
// is captured together with its carry. The zero, negative and (optionally)
// parity flags are computed from in_data when it is captured. The stage holds
// one main entry, which drives the outputs, and one skid entry. With the skid
// entry, upstream can stream at full rate while in_ready stays a plain
// register.
//
// Optional feature macro: ALU_RESULT_PARITY_EN
//   defined   : out_parity = XOR of the captured data bits. The parity bit is
//               stored in both the main and the skid entries.
//   undefined : out_parity is tied to 0 and no parity storage is built.
//
// Handshake: a transfer occurs on a rising edge where valid and ready are both
// 1. While valid is high and ready is low, the producer holds its payload
// stable, and valid does not drop until the transfer completes.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream result valid
//   in_ready   stage can accept (registered, low only when FULL)
//   in_data    mux output y
//   in_carry   carry/borrow aligned with in_data
//   out_valid  result available
//   out_ready  consumer accepts
//   out_data   registered result
//   out_carry  registered carry
//   out_zero   out_data == 0
//   out_neg    out_data MSB
//   out_parity XOR of out_data bits (0 when the feature is disabled)
//   out_count  completed output transfers, modulo 2^COUNT_W
// ---------------------------------------------------------------------------
module alu_result_stage #(
   parameter int DATA_W  = 8,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_carry,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_carry,
   output logic               out_zero,
   output logic               out_neg,
   output logic               out_parity,
   output logic [COUNT_W-1:0] out_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              carry;
      logic              zero;
      logic              neg;
`ifdef ALU_RESULT_PARITY_EN
      logic              parity;
`endif
   } entry_t;

   state_t state_q;
   state_t state_d;
   entry_t in_entry;
   entry_t main_q;
   entry_t skid_q;
   logic   load_main_in;
   logic   load_main_skid;
   logic   load_skid;
   logic   in_xfer;
   logic   out_xfer;
   logic   [COUNT_W-1:0] count_q;

   // The flags come from the incoming data, so they travel with their entry.
   always_comb begin
      in_entry       = '0;
      in_entry.data  = in_data;
      in_entry.carry = in_carry;
      in_entry.zero  = (in_data == '0);
      in_entry.neg   = in_data[DATA_W-1];
`ifdef ALU_RESULT_PARITY_EN
      in_entry.parity = ^in_data;
`endif
   end

   assign out_valid = (state_q == ONE) || (state_q == FULL);
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;

   // Next-state logic and datapath load enables.
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d      = ONE;
               load_main_in = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               state_d      = ONE;
               load_main_in = 1'b1;
            end else if (in_xfer) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so any upstream valid is ignored.
            if (out_xfer) begin
               state_d        = ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // in_ready is registered from the next state. This keeps out_ready off
   // any combinational path to in_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready <= 1'b1;
      end else begin
         in_ready <= (state_d != FULL);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
      end else if (load_main_in) begin
         main_q <= in_entry;
      end else if (load_main_skid) begin
         main_q <= skid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_q <= '0;
      end else if (load_skid) begin
         skid_q <= in_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (out_xfer) begin
         count_q <= count_q + COUNT_W'(1);
      end
   end

   assign out_data  = main_q.data;
   assign out_carry = main_q.carry;
   assign out_zero  = main_q.zero;
   assign out_neg   = main_q.neg;
   assign out_count = count_q;
`ifdef ALU_RESULT_PARITY_EN
   assign out_parity = main_q.parity;
`else
   assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//
// Bench for alu_result_stage. The driver pushes the expected output entry
// when an input is accepted. The monitor pops and compares that entry on each
// output transfer. The monitor also tracks out_count, and it checks that the
// outputs hold stable while the consumer stalls.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

   localparam int DATA_W  = 8;
   localparam int COUNT_W = 8;
   localparam int EW      = DATA_W + 4;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_data;
   logic               in_carry;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic               out_carry;
   logic               out_zero;
   logic               out_neg;
   logic               out_parity;
   logic [COUNT_W-1:0] out_count;

   // Entry layout: {parity, neg, zero, carry, data}
   logic [EW-1:0] exp_q[$];
   int            checks;
   int            errors;
   int            stalls;
   logic [COUNT_W-1:0] tb_count;
   logic          held;
   logic [EW-1:0] held_val;

   alu_result_stage #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_carry   (in_carry),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_carry  (out_carry),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_parity (out_parity),
      .out_count  (out_count)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] model(input logic [DATA_W-1:0] d, input logic c);
      logic par;
`ifdef ALU_RESULT_PARITY_EN
      par = ^d;
`else
      par = 1'b0;
`endif
      return {par, d[DATA_W-1], (d == '0), c, d};
   endfunction

   // Drive one input and wait until it is accepted. The task is entered and
   // exits one time unit after a rising edge, with in_valid still high so
   // that calls can run back to back.
   task automatic send(input logic [DATA_W-1:0] d, input logic c);
      int waits;
      waits    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_carry = c;
      while (1) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(model(d, c));
            @(posedge clk);
            #1;
            break;
         end
         waits++;
         if (waits > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck low for data 0x%0h", d);
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (waits > 0) stalls++;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 || out_valid) begin
         @(posedge clk);
         #2;
         n++;
         if (n > 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries still expected", exp_q.size());
            break;
         end
      end
   endtask

   // Apply a reset that is asserted and released between clock edges.
   task automatic pulse_reset();
      #1;
      rst = 1'b1;
      exp_q.delete();
      tb_count = '0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_count", {24'd0, out_count}, 32'd0);
      check("rst_outputs", {20'd0, out_parity, out_neg, out_zero, out_carry, out_data}, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         held <= 1'b0;
      end else begin
         check("out_count", {24'd0, out_count}, {24'd0, tb_count});
         if (held) begin
            check("hold_stable", {20'd0, out_valid, out_parity, out_neg, out_zero, out_carry, out_data},
                  {20'd0, 1'b1, held_val});
         end
         if (out_valid && !out_ready) begin
            held     <= 1'b1;
            held_val <= {out_parity, out_neg, out_zero, out_carry, out_data};
         end else begin
            held <= 1'b0;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got data 0x%0h with nothing expected", out_data);
            end else begin
               check("out_entry", {20'd0, out_parity, out_neg, out_zero, out_carry, out_data},
                     {20'd0, exp_q.pop_front()});
            end
            tb_count <= tb_count + 8'd1;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      checks    = 0;
      errors    = 0;
      stalls    = 0;
      tb_count  = '0;
      held      = 1'b0;
      held_val  = '0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_carry  = 1'b0;
      out_ready = 1'b0;

      // Reset then idle.
      #3;
      pulse_reset();
      check("idle_after_reset", {31'd0, out_valid}, 32'd0);

      // Single transfer with zero result and carry set.
      out_ready = 1'b1;
      send(8'h00, 1'b1);
      idle();
      check("single_valid", {31'd0, out_valid}, 32'd1);
      check("single_data", {24'd0, out_data}, 32'h00);
      check("single_carry", {31'd0, out_carry}, 32'd1);
      check("single_zero", {31'd0, out_zero}, 32'd1);
      check("single_neg", {31'd0, out_neg}, 32'd0);
      drain();
      check("single_count", {24'd0, out_count}, 32'd1);

      // Backpressure: the second entry fills the skid register.
      out_ready = 1'b0;
      send(8'h81, 1'b0);
      send(8'h05, 1'b1);
      idle();
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_hold_data", {24'd0, out_data}, 32'h81);
      check("bp_hold_neg", {31'd0, out_neg}, 32'd1);
      wait_cycles(3);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
      check("bp_second_data", {24'd0, out_data}, 32'h05);
      drain();
      check("bp_count", {24'd0, out_count}, 32'd3);

      // Reset while FULL: buffered entries must never reach the output.
      out_ready = 1'b0;
      send(8'hA5, 1'b0);
      send(8'h5A, 1'b1);
      idle();
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      pulse_reset();
      out_ready = 1'b1;
      wait_cycles(2);
      check("post_full_reset_empty", {31'd0, out_valid}, 32'd0);
      send(8'h3C, 1'b0);
      idle();
      drain();
      check("post_full_reset_count", {24'd0, out_count}, 32'd1);

`ifdef ALU_RESULT_PARITY_EN
      // Parity values are checked while the output is stalled.
      out_ready = 1'b0;
      send(8'h07, 1'b0);
      idle();
      check("parity_07", {31'd0, out_parity}, 32'd1);
      out_ready = 1'b1;
      drain();
      out_ready = 1'b0;
      send(8'h03, 1'b0);
      idle();
      check("parity_03", {31'd0, out_parity}, 32'd0);
      out_ready = 1'b1;
      drain();
`endif

      // Streaming: 300 back-to-back results with the consumer always ready.
      pulse_reset();
      out_ready = 1'b1;
      stalls    = 0;
      for (int i = 0; i < 300; i++) begin
         send(i[7:0], i[0]);
      end
      idle();
      check("stream_no_stall", stalls, 32'd0);
      drain();
      check("stream_count_wrap", {24'd0, out_count}, 32'd44);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
